blink_rate_select: RTL and testbench
====================================

BLINK_RATE_SELECT -- requirements
Module: blink_rate_select

Interface
REQ-001 SHALL have parameter g_DEBOUNCE_LIMIT, default 250000, meaning cycles a raw level must hold before acceptance (10 ms at 25 MHz).
REQ-002 SHALL have port i_Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_Switch  input  1  raw push-button level, asynchronous to i_Clk, bouncing.
REQ-005 SHALL have ports i_LED_10HZ, i_LED_5HZ, i_LED_2HZ, i_LED_1HZ  input  1 each  toggle outputs of the upstream blinker.
REQ-006 SHALL have port o_LED  output  1  selected blink signal to the board LED.
REQ-007 SHALL have port o_Sel  output  2  current selection code.
REQ-008 SHALL have port o_Press  output  1  one-cycle pulse per accepted button release.
REQ-009 SHALL have port o_Off  output  1  high while in S_OFF.

Function
REQ-010 SHALL synchronize i_Switch through two flops (r_Sync1, r_Sync2) before any other use.
REQ-011 Debounce counter SHALL increment each cycle while r_Sync2 != r_Stable, and SHALL clear to 0 whenever r_Sync2 == r_Stable (bounce restarts the count).
REQ-012 When r_Sync2 != r_Stable and counter == g_DEBOUNCE_LIMIT-1, r_Stable SHALL take r_Sync2 and the counter SHALL clear, on the same edge.
REQ-013 A raw level change held steady SHALL appear on r_Stable exactly 2 + g_DEBOUNCE_LIMIT cycles after the first sampling edge.
REQ-014 o_Press SHALL be high for exactly one cycle, the cycle after r_Stable goes 1->0 (release); a press alone SHALL NOT pulse.
REQ-015 Selection FSM states SHALL be S_10HZ (o_Sel=0), S_5HZ (1), S_2HZ (2), S_1HZ (3), and S_OFF (o_Sel=3, o_Off=1) when compiled in.
REQ-016 FSM SHALL advance one state on the same edge that asserts o_Press; with no press it SHALL hold.
REQ-017 Order SHALL be S_10HZ -> S_5HZ -> S_2HZ -> S_1HZ -> (S_OFF ->) S_10HZ, wrapping.
REQ-018 o_LED SHALL be a registered mux of the input matching the current state (1-cycle latency from the input), forced 0 in S_OFF.
REQ-019 On a state change, o_LED SHALL reflect the new source on the following edge, with no extra blanking cycle.
REQ-020 Unreachable state encodings SHALL recover to S_10HZ on the next edge.
REQ-021 g_DEBOUNCE_LIMIT SHALL be >= 2; counter width SHALL be $clog2(g_DEBOUNCE_LIMIT)+1 so the compare never wraps.

Reset
REQ-022 While i_Rst=1, regardless of clock: sync flops, r_Stable, counter = 0; state = S_10HZ; o_LED=0, o_Sel=0, o_Press=0, o_Off=0.
REQ-023 Reset asserted mid-debounce or mid-pulse SHALL discard the pending count or pulse; no press SHALL be reported after release of reset unless a full new release is debounced.
REQ-024 Button held during reset deassertion SHALL be debounced as a fresh press (r_Stable starts 0).

Configuration
REQ-025 Macro BLINK_SEL_OFF_EN: when defined, S_OFF is present in the cycle and o_Off is driven per REQ-015; when undefined, the cycle is four states, S_1HZ wraps to S_10HZ, and o_Off is tied 0.

Verification (g_DEBOUNCE_LIMIT=4, inputs from a blinker with 10/5/2/1 Hz periods of 10/20/50/100 cycles)
REQ-026 After reset, drive i_LED_10HZ toggling -> o_LED follows it 1 cycle late; o_Sel=0; o_Press never pulses.
REQ-027 i_Switch 0->1 held 8 cycles then 1->0 held 8 cycles -> exactly one o_Press pulse, 6 cycles after the falling raw edge; o_Sel 0->1 the same edge.
REQ-028 i_Switch bouncing 1,0,1,0 at 1-cycle intervals then steady 0 -> counter restarts each bounce; no o_Press until 4 steady cycles are met.
REQ-029 Five clean press/release cycles -> o_Sel sequence 1,2,3,0,1 without BLINK_SEL_OFF_EN; with it, 1,2,3,3(o_Off=1, o_LED=0),0.
REQ-030 Assert i_Rst for 1 cycle 2 cycles after a raw release -> no o_Press, o_Sel=0, o_LED=0 immediately (asynchronously).

Source files
------------

// File: rtl/blink_rate_select.sv
// Button-driven blink-rate selector: synchronizes and debounces a push button and
// steps through 10/5/2/1 Hz LED sources on each release. Optional S_OFF state via BLINK_SEL_OFF_EN.
module blink_rate_select #(
  parameter int unsigned g_DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  input  logic       i_LED_10HZ,
  input  logic       i_LED_5HZ,
  input  logic       i_LED_2HZ,
  input  logic       i_LED_1HZ,
  output logic       o_LED,
  output logic [1:0] o_Sel,
  output logic       o_Press,
  output logic       o_Off
);

  // One spare bit keeps the terminal-count compare from wrapping; limit must be >= 2.
  localparam int unsigned CNT_W = $clog2(g_DEBOUNCE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(g_DEBOUNCE_LIMIT - 1);

  typedef enum logic [2:0] {
    S_10HZ = 3'd0,
    S_5HZ  = 3'd1,
    S_2HZ  = 3'd2,
    S_1HZ  = 3'd3,
    S_OFF  = 3'd4
  } state_t;

  logic             r_Sync1;
  logic             r_Sync2;
  logic             r_Stable;
  logic [CNT_W-1:0] r_Count;
  logic             accept_c;
  logic             release_c;

  state_t     state;
  state_t     state_next;
  logic       led_c;
  logic [1:0] sel_c;

  assign accept_c  = (r_Sync2 != r_Stable) && (r_Count == CNT_LAST);
  assign release_c = accept_c && r_Stable;

  // Two-flop synchronizer and debounce counter; any bounce back to r_Stable restarts the count.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Sync1  <= 1'b0;
      r_Sync2  <= 1'b0;
      r_Stable <= 1'b0;
      r_Count  <= '0;
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
      if ((r_Sync2 == r_Stable) || accept_c) begin
        r_Count <= '0;
      end else begin
        r_Count <= r_Count + CNT_W'(1);
      end
      if (accept_c) begin
        r_Stable <= r_Sync2;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= S_10HZ;
    end else begin
      state <= state_next;
    end
  end

  // Advance on the debounced release; illegal encodings fall back to S_10HZ.
  always_comb begin
    state_next = state;
    case (state)
      S_10HZ: if (release_c) state_next = S_5HZ;
      S_5HZ:  if (release_c) state_next = S_2HZ;
      S_2HZ:  if (release_c) state_next = S_1HZ;
`ifdef BLINK_SEL_OFF_EN
      S_1HZ:  if (release_c) state_next = S_OFF;
      S_OFF:  if (release_c) state_next = S_10HZ;
`else
      S_1HZ:  if (release_c) state_next = S_10HZ;
`endif
      default: state_next = S_10HZ;
    endcase
  end

  // LED source follows the present state; the selection code follows the next state.
  always_comb begin
    led_c = 1'b0;
    sel_c = 2'd0;
    case (state)
      S_10HZ:  led_c = i_LED_10HZ;
      S_5HZ:   led_c = i_LED_5HZ;
      S_2HZ:   led_c = i_LED_2HZ;
      S_1HZ:   led_c = i_LED_1HZ;
      default: led_c = 1'b0;
    endcase
    case (state_next)
      S_5HZ:   sel_c = 2'd1;
      S_2HZ:   sel_c = 2'd2;
      S_1HZ:   sel_c = 2'd3;
      S_OFF:   sel_c = 2'd3;
      default: sel_c = 2'd0;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_LED   <= 1'b0;
      o_Sel   <= 2'd0;
      o_Press <= 1'b0;
    end else begin
      o_LED   <= led_c;
      o_Sel   <= sel_c;
      o_Press <= release_c;
    end
  end

`ifdef BLINK_SEL_OFF_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Off <= 1'b0;
    end else begin
      o_Off <= (state_next == S_OFF);
    end
  end
`else
  assign o_Off = 1'b0;
`endif

endmodule

// File: tb/tb_blink_rate_select.sv
// Randomized self-checking bench for blink_rate_select against a window-based behavioural model.
module tb_blink_rate_select;

  localparam int unsigned LIMIT = 4;
`ifdef BLINK_SEL_OFF_EN
  localparam int NSTATES = 5;
`else
  localparam int NSTATES = 4;
`endif

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Switch = 1'b0;
  logic       i_LED_10HZ = 1'b0;
  logic       i_LED_5HZ = 1'b0;
  logic       i_LED_2HZ = 1'b0;
  logic       i_LED_1HZ = 1'b0;
  logic       o_LED;
  logic [1:0] o_Sel;
  logic       o_Press;
  logic       o_Off;

  always #5 i_Clk = ~i_Clk;

  blink_rate_select #(.g_DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
    .i_LED_10HZ(i_LED_10HZ), .i_LED_5HZ(i_LED_5HZ),
    .i_LED_2HZ(i_LED_2HZ), .i_LED_1HZ(i_LED_1HZ),
    .o_LED(o_LED), .o_Sel(o_Sel), .o_Press(o_Press), .o_Off(o_Off)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   presses = 0;
  logic hist[$];
  logic m_stable;
  int   m_state;
  logic m_led;
  logic m_press;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(LIMIT) + 2; i++) hist.push_back(1'b0);
    m_stable = 1'b0;
    m_state  = 0;
    m_led    = 1'b0;
    m_press  = 1'b0;
  endtask

  // A new level is accepted once the raw samples taken 2..LIMIT+1 edges ago all disagree with it.
  task automatic model_edge(input logic sw, input logic [3:0] leds);
    logic flip;
    hist.push_front(sw);
    void'(hist.pop_back());
    flip = 1'b1;
    for (int i = 2; i <= int'(LIMIT) + 1; i++) if (hist[i] == m_stable) flip = 1'b0;
    m_led   = (m_state < 4) ? leds[m_state] : 1'b0;
    m_press = flip && m_stable;
    if (flip) m_stable = ~m_stable;
    if (m_press) m_state = (m_state + 1) % NSTATES;
  endtask

  task automatic check_outputs();
    check("led", int'(o_LED), int'(m_led));
    check("sel", int'(o_Sel), (m_state > 3) ? 3 : m_state);
    check("press", int'(o_Press), int'(m_press));
    check("off", int'(o_Off), (m_state == 4) ? 1 : 0);
  endtask

  task automatic step(input logic sw);
    logic [3:0] leds;
    leds[0] = ((cyc / 5) % 2) != 0;
    leds[1] = ((cyc / 10) % 2) != 0;
    leds[2] = ((cyc / 25) % 2) != 0;
    leds[3] = ((cyc / 50) % 2) != 0;
    i_Switch   = sw;
    i_LED_10HZ = leds[0];
    i_LED_5HZ  = leds[1];
    i_LED_2HZ  = leds[2];
    i_LED_1HZ  = leds[3];
    @(posedge i_Clk);
    if (!i_Rst) model_edge(sw, leds);
    cyc++;
    @(negedge i_Clk);
    if (o_Press) presses++;
    check_outputs();
  endtask

  // Asynchronous reset between edges; outputs must clear before the next clock.
  task automatic do_reset();
    #2;
    i_Rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1'b0;
  endtask

  int lat;
  int exp_sel[5];

  initial begin
`ifdef BLINK_SEL_OFF_EN
    exp_sel = '{1, 2, 3, 3, 0};
`else
    exp_sel = '{1, 2, 3, 0, 1};
`endif
    model_reset();
    @(negedge i_Clk);
    do_reset();

    // Idle: LED follows the 10 Hz source, no presses.
    presses = 0;
    for (int i = 0; i < 30; i++) step(1'b0);
    check("idle_presses", presses, 0);

    // Clean press then release: pulse 6 edges after the raw fall.
    for (int i = 0; i < 8; i++) step(1'b1);
    lat = 0;
    while (lat < 12) begin
      step(1'b0);
      lat++;
      if (o_Press) break;
    end
    check("press_lat", lat, 6);
    check("sel_after_1", int'(o_Sel), 1);
    for (int i = 0; i < 4; i++) step(1'b0);

    // Bouncy release: exactly one pulse once the level settles.
    for (int i = 0; i < 8; i++) step(1'b1);
    presses = 0;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    for (int i = 0; i < 12; i++) step(1'b0);
    check("bounce_presses", presses, 1);

    // Five clean press/release cycles from reset.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 8; i++) step(1'b1);
      for (int i = 0; i < 8; i++) step(1'b0);
      check("seq_sel", int'(o_Sel), exp_sel[p]);
    end

    // Reset shortly after a raw release discards the pending press.
    for (int i = 0; i < 8; i++) step(1'b1);
    step(1'b0); step(1'b0);
    do_reset();
    presses = 0;
    for (int i = 0; i < 10; i++) step(1'b0);
    check("rst_presses", presses, 0);

    // Button held through reset release is a fresh press.
    i_Switch = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);

    // Random levels, bursts of bounce and occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 10));
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 4; b++) step(1'(b % 2));
      end
      for (int i = 0; i < len; i++) step(lvl);
      if ($urandom_range(0, 14) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
